// File: rtl/load_store_unit.sv
// Load/store front end: turns a RISC-V load/store into one or two word-aligned
// byte-enabled memory accesses, with lane-shifted store data and extended load data.
module load_store_unit #(
    parameter int ADRESS_SIZE = 32,
    parameter int BIT_COUNT   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ReqValid,
    input  logic                     ReqWrite,
    input  logic [2:0]               ReqFunct3,
    input  logic [ADRESS_SIZE-1:0]   ReqAdress,
    input  logic [BIT_COUNT-1:0]     ReqStoreData,
    output logic                     Stall,
    output logic                     RespValid,
    output logic [BIT_COUNT-1:0]     LoadData,
    output logic                     ReqError,
    output logic                     MemEn,
    output logic                     WriteEnable,
    output logic [BIT_COUNT/8-1:0]   ByteEn,
    output logic [ADRESS_SIZE-1:0]   MemoryAdress,
    output logic [BIT_COUNT-1:0]     InputData,
    input  logic [BIT_COUNT-1:0]     MemData
);

    typedef enum logic {IDLE, SECOND} state_t;

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [2:0]               funct3_q, funct3_d;
    logic [1:0]               off_q, off_d;
    logic [ADRESS_SIZE-1:0]   next_addr_q, next_addr_d;
    logic [BIT_COUNT-1:0]     store_hi_q, store_hi_d;
    logic [BIT_COUNT-1:0]     low_word_q, low_word_d;
    logic [BIT_COUNT/8-1:0]   be_hi_q, be_hi_d;

    logic [1:0]               off;
    logic [7:0]               size_mask;
    logic [7:0]               mask;
    logic                     legal;
    logic                     misaligned;
    logic [ADRESS_SIZE-1:0]   base;
    logic [2*BIT_COUNT-1:0]   store_wide;

    // Shift the {high,low} word pair down to the access offset, keep n bytes, extend.
    function automatic logic [BIT_COUNT-1:0] extend_load(
        input logic [2*BIT_COUNT-1:0] pair,
        input logic [1:0]             o,
        input logic [2:0]             f3
    );
        logic [BIT_COUNT-1:0] w;
        w = BIT_COUNT'(pair >> {o, 3'b000});
        case (f3[1:0])
            2'b00:   extend_load = {{(BIT_COUNT-8){w[7] & ~f3[2]}}, w[7:0]};
            2'b01:   extend_load = {{(BIT_COUNT-16){w[15] & ~f3[2]}}, w[15:0]};
            default: extend_load = w;
        endcase
    endfunction

    always_comb begin
        off = ReqAdress[1:0];
        case (ReqFunct3[1:0])
            2'b00:   size_mask = 8'b0000_0001;
            2'b01:   size_mask = 8'b0000_0011;
            default: size_mask = 8'b0000_1111;
        endcase
        mask = size_mask << off;
        case (ReqFunct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~ReqWrite;
            default:                legal = 1'b0;
        endcase
        misaligned = |mask[7:4];
        base       = {ReqAdress[ADRESS_SIZE-1:2], 2'b00};
        store_wide = {{BIT_COUNT{1'b0}}, ReqStoreData} << {off, 3'b000};
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        next_addr_d  = next_addr_q;
        store_hi_d   = store_hi_q;
        low_word_d   = low_word_q;
        be_hi_d      = be_hi_q;
        Stall        = 1'b0;
        RespValid    = 1'b0;
        LoadData     = '0;
        ReqError     = 1'b0;
        MemEn        = 1'b0;
        WriteEnable  = 1'b0;
        ByteEn       = '0;
        MemoryAdress = '0;
        InputData    = '0;
        // Outputs are forced quiet while reset is held, not just after the edge.
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (ReqValid && !legal) begin
                        ReqError = 1'b1;
                    end else if (ReqValid) begin
                        MemEn        = 1'b1;
                        WriteEnable  = ReqWrite;
                        MemoryAdress = base;
                        ByteEn       = mask[3:0];
                        InputData    = store_wide[BIT_COUNT-1:0];
                        if (misaligned) begin
                            Stall       = 1'b1;
                            state_d     = SECOND;
                            write_d     = ReqWrite;
                            funct3_d    = ReqFunct3;
                            off_d       = off;
                            next_addr_d = base + ADRESS_SIZE'(4);
                            store_hi_d  = store_wide[2*BIT_COUNT-1:BIT_COUNT];
                            low_word_d  = MemData;
                            be_hi_d     = mask[7:4];
                        end else if (!ReqWrite) begin
                            RespValid = 1'b1;
                            LoadData  = extend_load({{BIT_COUNT{1'b0}}, MemData}, off, ReqFunct3);
                        end
                    end
                end
                SECOND: begin
                    MemEn        = 1'b1;
                    WriteEnable  = write_q;
                    MemoryAdress = next_addr_q;
                    ByteEn       = be_hi_q;
                    InputData    = store_hi_q;
                    state_d      = IDLE;
                    if (!write_q) begin
                        RespValid = 1'b1;
                        LoadData  = extend_load({MemData, low_word_q}, off_q, funct3_q);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            next_addr_q <= '0;
            store_hi_q  <= '0;
            low_word_q  <= '0;
            be_hi_q     <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            next_addr_q <= next_addr_d;
            store_hi_q  <= store_hi_d;
            low_word_q  <= low_word_d;
            be_hi_q     <= be_hi_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference model predicts every
// memory beat; a negedge monitor pops and compares whenever the DUT is active.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [2:0]  ReqFunct3;
    logic [31:0] ReqAdress;
    logic [31:0] ReqStoreData;
    logic        Stall;
    logic        RespValid;
    logic [31:0] LoadData;
    logic        ReqError;
    logic        MemEn;
    logic        WriteEnable;
    logic [3:0]  ByteEn;
    logic [31:0] MemoryAdress;
    logic [31:0] InputData;
    logic [31:0] MemData;

    load_store_unit #(.ADRESS_SIZE(32), .BIT_COUNT(32)) dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
        .ReqFunct3(ReqFunct3), .ReqAdress(ReqAdress), .ReqStoreData(ReqStoreData),
        .Stall(Stall), .RespValid(RespValid), .LoadData(LoadData), .ReqError(ReqError),
        .MemEn(MemEn), .WriteEnable(WriteEnable), .ByteEn(ByteEn),
        .MemoryAdress(MemoryAdress), .InputData(InputData), .MemData(MemData)
    );

    typedef struct packed {
        logic        mem_en;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        stall;
        logic        rv;
        logic [31:0] ld;
        logic        err;
    } beat_t;

    beat_t       exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_load;

    logic [31:0] dmem [0:15];
    logic [7:0]  ref_mem [0:63];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign MemData = dmem[MemoryAdress[5:2]];

    always @(posedge clk) begin
        if (MemEn && WriteEnable) begin
            for (int l = 0; l < 4; l++)
                if (ByteEn[l]) dmem[MemoryAdress[5:2]][8*l +: 8] <= InputData[8*l +: 8];
        end
    end

    always @(negedge clk) begin
        beat_t act, e;
        if (MemEn || Stall || RespValid || ReqError) begin
            act = '{MemEn, WriteEnable, MemoryAdress, ByteEn, InputData, Stall, RespValid, LoadData, ReqError};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_beat: got %h, none expected", act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_errors++;
                    $display("FAIL beat @%0t: got %h, expected %h", $time, act, e);
                end
            end
            if (RespValid) last_load = LoadData;
        end else begin
            n_checks++;
            if ({WriteEnable, ByteEn, MemoryAdress, InputData, LoadData} !== '0) begin
                n_errors++;
                $display("FAIL idle_zero: got we=%b be=%b addr=%h wd=%h ld=%h, expected all 0",
                         WriteEnable, ByteEn, MemoryAdress, InputData, LoadData);
            end
        end
    end

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({Stall, RespValid, MemEn, WriteEnable, ByteEn, ReqError, MemoryAdress, InputData, LoadData} !== '0) begin
            n_errors++;
            $display("FAIL %s: got stall=%b rv=%b en=%b we=%b be=%b err=%b addr=%h wd=%h ld=%h, expected all 0",
                     name, Stall, RespValid, MemEn, WriteEnable, ByteEn, ReqError, MemoryAdress, InputData, LoadData);
        end
    endtask

    task automatic check_load(input string name, input logic [31:0] want);
        n_checks++;
        if (last_load !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, last_load, want);
        end
    endtask

    // Called at posedge+1; drives one request, predicts its beats, and returns at posedge+1.
    // With abort set, reset is asserted during the second beat.
    task automatic issue(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                         input bit [31:0] d, input bit abort);
        beat_t       b0, b1;
        int          n, o, lane;
        bit          legal, mis;
        logic [31:0] v;
        legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!wr && (f3 == 3'd4 || f3 == 3'd5));
        o = int'(a[1:0]);
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis = legal && (o + n > 4);
        b0 = '0;
        b1 = '0;
        v = '0;
        if (!legal) begin
            b0.err = 1'b1;
        end else begin
            b0.mem_en = 1'b1;
            b0.we     = wr;
            b0.addr   = a & ~32'd3;
            b1.mem_en = 1'b1;
            b1.we     = wr;
            b1.addr   = (a & ~32'd3) + 32'd4;
            for (int i = 0; i < 4; i++) begin
                lane = o + i;
                if (lane < 4) b0.wdata[8*lane +: 8] = d[8*i +: 8];
                else          b1.wdata[8*(lane-4) +: 8] = d[8*i +: 8];
            end
            for (int i = 0; i < n; i++) begin
                lane = o + i;
                if (lane < 4) b0.be[lane] = 1'b1;
                else          b1.be[lane-4] = 1'b1;
                v[8*i +: 8] = ref_mem[(a + i) & 32'd63];
                if (wr && (!abort || lane < 4)) ref_mem[(a + i) & 32'd63] = d[8*i +: 8];
            end
            if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
            if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
            if (mis) begin
                b0.stall = 1'b1;
                b1.rv    = !wr;
                b1.ld    = wr ? 32'd0 : v;
            end else begin
                b0.rv = !wr;
                b0.ld = wr ? 32'd0 : v;
            end
        end
        exp_q.push_back(b0);
        if (mis && !abort) exp_q.push_back(b1);
        last_load    = 32'hDEAD_DEAD;
        ReqValid     = 1'b1;
        ReqWrite     = wr;
        ReqFunct3    = f3;
        ReqAdress    = a;
        ReqStoreData = d;
        @(posedge clk);
        #1;
        if (mis) begin
            if (abort) begin
                reset    = 1'b1;
                ReqValid = 1'b0;
                #1;
                check_all_zero("reset_during_second");
                @(negedge clk);
                #2;
                reset = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        ReqValid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        ReqValid = 1'b0;
        ReqWrite = 1'b0;
        ReqFunct3 = '0;
        ReqAdress = '0;
        ReqStoreData = '0;
        reset = 1'b1;
        last_load = '0;
        for (int k = 0; k < 16; k++) begin
            w = (k == 0) ? 32'h4433_2211 : (k == 1) ? 32'h8877_6655 : $urandom;
            dmem[k] = w;
            for (int b = 0; b < 4; b++) ref_mem[4*k + b] = w[8*b +: 8];
        end
        #2;
        ReqValid = 1'b1;
        ReqAdress = 32'h3;
        #1;
        check_all_zero("reset_state");
        ReqValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        issue(0, 3'b010, 32'h0, 32'h0, 0);  check_load("lw_0", 32'h4433_2211);
        issue(0, 3'b000, 32'h7, 32'h0, 0);  check_load("lb_7", 32'hFFFF_FF88);
        issue(0, 3'b100, 32'h7, 32'h0, 0);  check_load("lbu_7", 32'h0000_0088);
        issue(0, 3'b001, 32'h2, 32'h0, 0);  check_load("lh_2", 32'h0000_4433);
        issue(0, 3'b010, 32'h2, 32'h0, 0);  check_load("lw_2_split", 32'h6655_4433);
        issue(1, 3'b001, 32'h3, 32'h0000_BEEF, 0);
        issue(0, 3'b010, 32'h0, 32'h0, 0);  check_load("readback_w0", 32'hEF33_2211);
        issue(0, 3'b010, 32'h4, 32'h0, 0);  check_load("readback_w1", 32'h8877_66BE);
        issue(1, 3'b010, 32'h1, 32'hA1B2_C3D4, 1);
        issue(0, 3'b010, 32'h4, 32'h0, 0);  check_load("w1_after_abort", 32'h8877_66BE);
        issue(0, 3'b010, 32'h0, 32'h0, 0);  check_load("w0_after_abort", 32'hB2C3_D411);
        issue(0, 3'b011, 32'h0, 32'h0, 0);
        issue(1, 3'b100, 32'h0, 32'h0000_0055, 0);
        issue(0, 3'b010, 32'h0, 32'h0, 0);  check_load("w0_after_errors", 32'hB2C3_D411);
        issue(0, 3'b010, 32'hFFFF_FFFE, 32'h0, 0);
        issue(1, 3'b001, 32'hFFFF_FFFF, 32'h1234_5678, 0);

        for (int t = 0; t < 400; t++) begin
            issue($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom, $urandom, 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL pending_beats: got %0d left, expected 0", exp_q.size());
        end
        for (int k = 0; k < 16; k++) begin
            w = {ref_mem[4*k+3], ref_mem[4*k+2], ref_mem[4*k+1], ref_mem[4*k]};
            n_checks++;
            if (dmem[k] !== w) begin
                n_errors++;
                $display("FAIL mem_word%0d: got %h, expected %h", k, dmem[k], w);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end between the execute/memory pipeline stage and the byte-enabled word memory. Converts a RISC-V load/store request (address, funct3, store data) into word-aligned memory accesses: byte enables, lane-shifted write data, and sign/zero-extended load data. An access that crosses a word boundary is split into two consecutive memory accesses, and the pipeline is stalled for one cycle.

## Interface
- ADRESS_SIZE, 32, byte-address width.
- BIT_COUNT, 32, data word width; only 32 is supported (4 byte lanes).
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  pipeline presents an access this cycle.
- ReqWrite  in  1  1 = store, 0 = load.
- ReqFunct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; 100/101 are legal for loads only.
- ReqAdress  in  ADRESS_SIZE  byte address.
- ReqStoreData  in  BIT_COUNT  store data, right-justified.
- Stall  out  1  pipeline must hold the request and not advance.
- RespValid  out  1  LoadData valid (loads only).
- LoadData  out  BIT_COUNT  extended load result.
- ReqError  out  1  illegal funct3; the access is dropped.
- MemEn, WriteEnable  out  1 each  to memory.
- ByteEn  out  BIT_COUNT/8  lane write enables.
- MemoryAdress  out  ADRESS_SIZE  word-aligned byte address (low 2 bits always 0).
- InputData  out  BIT_COUNT  lane-aligned write data.
- MemData  in  BIT_COUNT  memory read data, combinational on MemoryAdress.

## Operation
- Size in bytes: n = 1, 2, or 4 from funct3[1:0]. Offset: o = ReqAdress[1:0]. 8-bit lane mask: M = ((1<<n)-1)<<o.
- Misaligned means M[7:4] != 0. Base address is ReqAdress with the low 2 bits cleared. Next address is base+4, modulo 2^ADRESS_SIZE (wraps at the top).
- Store data: S = ReqStoreData<<(8*o), 64 bits wide. The low access drives S[31:0]; the high access drives S[63:32].
- States:
  - IDLE:
    - ReqValid with a legal op: drive MemEn=1, WriteEnable=ReqWrite, MemoryAdress=base, ByteEn=M[3:0], InputData=S[31:0].
    - Aligned: complete in the same cycle with Stall=0. For loads, RespValid=1.
    - Misaligned: Stall=1. Register op, o, n, next address, S[63:32], and MemData as LowWord. Go to SECOND.
  - SECOND:
    - Drive MemEn=1, WriteEnable=stored op, MemoryAdress=next, ByteEn=M[7:4], InputData=stored S[63:32].
    - Stall=0. For loads, RespValid=1. Go to IDLE.
    - Request inputs are ignored in this state (the pipeline is holding the same request).
- Load result: W = {high word, low word}>>(8*o). Take the low n bytes. Sign-extend for funct3 000/001, zero-extend for 010/100/101.
  - Aligned: high word is 0 and low word is MemData.
  - SECOND: high word is MemData and low word is LowWord.
- Illegal funct3 (011, 110, 111, or store with 100/101): ReqError=1, MemEn=0, Stall=0, RespValid=0.
- When nothing is active, all memory outputs, Stall, RespValid, ReqError, and LoadData are 0.

## Timing
- Aligned access: 0-cycle latency. Memory and LoadData are combinational in the request cycle. A store writes at the following clk edge.
- Misaligned access: 2 cycles. Stall=1 in cycle 1 only. RespValid and the second write occur in cycle 2. The pipeline advances at the end of cycle 2, so a new request is seen no earlier than cycle 3.
- Back-to-back aligned accesses: one per cycle, with no bubbles.
- Reset, while asserted (asynchronous):
  - State goes to IDLE and all registers clear.
  - All outputs are 0: Stall=0, RespValid=0, MemEn=0, WriteEnable=0, ByteEn=0.
  - A reset during SECOND abandons the high half. A store's low half is already written; this is accepted.
- Release of reset: normal IDLE operation from the next edge.

## Test plan
Memory preload: word0=0x44332211, word1=0x88776655.

- LW @0x0 → same cycle: MemEn=1, ByteEn=1111, MemoryAdress=0x0, LoadData=0x44332211, RespValid=1, Stall=0.
- Byte loads, each completing in 1 cycle:
  - LB @0x7 → 0xFFFFFF88.
  - LBU @0x7 → 0x00000088.
  - LH @0x2 → 0x00004433.
- LW @0x2:
  - Cycle 1: MemoryAdress=0x0, ByteEn=1100, Stall=1.
  - Cycle 2: MemoryAdress=0x4, ByteEn=0011, RespValid=1, LoadData=0x66554433.
- SH @0x3, data 0x0000BEEF:
  - Cycle 1: ByteEn=1000, InputData=0xEF000000.
  - Cycle 2: MemoryAdress=0x4, ByteEn=0001, InputData=0x000000BE.
  - Readback: word0=0xEF332211, word1=0x887766BE.
- Reset asserted during SECOND of a misaligned SW @0x1 → outputs go to 0 immediately. Word1 is unchanged. The next LW @0x0 completes normally.
- Funct3=011 load, or SB with funct3=100 → ReqError=1, MemEn=0, Stall=0, memory unchanged.
